// File: rtl/addsub_count_unit.sv
// rtl/addsub_count_unit.sv - two-stage add/sub/accumulate/count datapath with flags
module addsub_count_unit #(
    parameter int          WIDTH   = 4,
    parameter int unsigned CNT_MAX = 32'hFFFF_FFFF >> (32 - WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             ovf,
    output logic             zero
);

    typedef enum logic [1:0] {
        MODE_ADD   = 2'b00,
        MODE_SUB   = 2'b01,
        MODE_ACC   = 2'b10,
        MODE_COUNT = 2'b11
    } mode_e;

    localparam int               MSB       = WIDTH - 1;
    localparam logic [WIDTH-1:0] CNT_MAX_W = CNT_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};

    // Stage-1 operand registers
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             cin_q;
    mode_e            mode_q;
    logic             v_q;

    // Stage-2 result registers (S doubles as accumulator / counter state)
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             ovf_q;
    logic             out_valid_q;

    // Combinational stage-2 results
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             add_ovf;
    logic             sub_ovf;
    logic             cnt_wrap;
    logic [WIDTH-1:0] nxt_s;
    logic             nxt_co;
    logic             nxt_ovf;

    // Capture the operation every cycle; clr kills whatever is being accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            cin_q  <= 1'b0;
            mode_q <= MODE_ADD;
            v_q    <= 1'b0;
        end else begin
            x_q    <= X;
            y_q    <= Y;
            cin_q  <= Cin;
            mode_q <= mode_e'(mode);
            v_q    <= in_valid & ~clr;
        end
    end

    // Compute the next result; ACC/COUNT feed back the live output register so chains have no gaps
    always_comb begin
        add_a    = (mode_q == MODE_ACC) ? s_q : x_q;
        add_b    = (mode_q == MODE_ACC) ? x_q : y_q;
        add_full = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin_q};
        // Borrow falls out of the extra top bit: it is set whenever X < Y + Cin
        sub_full = {1'b0, x_q} - {1'b0, y_q} - {{WIDTH{1'b0}}, cin_q};
        add_ovf  = (add_a[MSB] == add_b[MSB]) && (add_full[MSB] != add_a[MSB]);
        // Subtraction adds ~Y, so the operand signs must differ for overflow
        sub_ovf  = (x_q[MSB] != y_q[MSB]) && (sub_full[MSB] != x_q[MSB]);
        // Values above the terminal count (left by ADD/SUB/ACC) also wrap
        cnt_wrap = (s_q >= CNT_MAX_W);
        nxt_s    = add_full[WIDTH-1:0];
        nxt_co   = add_full[WIDTH];
        nxt_ovf  = add_ovf;
        case (mode_q)
            MODE_ADD, MODE_ACC: begin
                nxt_s   = add_full[WIDTH-1:0];
                nxt_co  = add_full[WIDTH];
                nxt_ovf = add_ovf;
            end
            MODE_SUB: begin
                nxt_s   = sub_full[WIDTH-1:0];
                nxt_co  = sub_full[WIDTH];
                nxt_ovf = sub_ovf;
            end
            MODE_COUNT: begin
                nxt_s   = cnt_wrap ? '0 : (s_q + ONE_W);
                nxt_co  = cnt_wrap;
                nxt_ovf = 1'b0;
            end
        endcase
    end

    // Result register: clr wins, otherwise update only on a valid stage-1 slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            s_q         <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (v_q) begin
            s_q         <= nxt_s;
            co_q        <= nxt_co;
            ovf_q       <= nxt_ovf;
            out_valid_q <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign S         = s_q;
    assign Co        = co_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign zero      = (s_q == '0);

endmodule

// File: tb/tb_addsub_count_unit.sv
// tb/tb_addsub_count_unit.sv - directed vector bench for addsub_count_unit
module tb_addsub_count_unit;

    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_SUB = 2'b01;
    localparam logic [1:0] M_ACC = 2'b10;
    localparam logic [1:0] M_CNT = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] mode;
    logic [3:0] X;
    logic [3:0] Y;
    logic       Cin;
    logic       clr;
    logic       out_valid;
    logic [3:0] S;
    logic       Co;
    logic       ovf;
    logic       zero;

    int n_chk;
    int n_fail;

    addsub_count_unit #(.WIDTH(4), .CNT_MAX(9)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
        .X(X), .Y(Y), .Cin(Cin), .clr(clr), .out_valid(out_valid),
        .S(S), .Co(Co), .ovf(ovf), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] m;
        logic [3:0] x;
        logic [3:0] y;
        logic       cin;
        logic [3:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t tbl[13];
    vec_t burst[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] x,
                         input logic [3:0] y, input logic c);
        in_valid = v;
        mode     = m;
        X        = x;
        Y        = y;
        Cin      = c;
    endtask

    task automatic chk_result(input string tag, input vec_t e);
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".S"}, S, e.s);
        chk({tag, ".Co"}, Co, e.co);
        chk({tag, ".ovf"}, ovf, e.ov);
        chk({tag, ".zero"}, zero, (e.s == 4'd0));
    endtask

    // Single isolated operation: idle before and after, two-edge latency
    task automatic do_op(input string tag, input vec_t e);
        drive(1'b1, e.m, e.x, e.y, e.cin);
        step();
        drive(1'b0, M_ADD, 4'd0, 4'd0, 1'b0);
        chk({tag, ".early_valid"}, out_valid, 0);
        step();
        chk_result(tag, e);
        step();
        chk({tag, ".idle_valid"}, out_valid, 0);
        chk({tag, ".idle_hold_S"}, S, e.s);
    endtask

    // Back-to-back operations: result of op j-1 is visible after edge j
    task automatic run_burst(input string tag, input int n);
        for (int j = 0; j <= n + 1; j++) begin
            if (j < n) drive(1'b1, burst[j].m, burst[j].x, burst[j].y, burst[j].cin);
            else       drive(1'b0, M_ADD, 4'd0, 4'd0, 1'b0);
            step();
            if (j == 0 || j == n + 1) chk({tag, ".gap_valid"}, out_valid, 0);
            else chk_result($sformatf("%s[%0d]", tag, j - 1), burst[j - 1]);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        clr    = 1'b0;
        drive(1'b0, M_ADD, 4'd0, 4'd0, 1'b0);

        // m, x, y, cin -> s, co, ovf ; S carries over between rows
        tbl[0]  = '{M_ADD, 4'd9,  4'd8, 1'b1, 4'd2,  1'b1, 1'b1};
        tbl[1]  = '{M_SUB, 4'd3,  4'd5, 1'b0, 4'd14, 1'b1, 1'b0};
        tbl[2]  = '{M_ADD, 4'd7,  4'd1, 1'b0, 4'd8,  1'b0, 1'b1};
        tbl[3]  = '{M_ACC, 4'd3,  4'd9, 1'b1, 4'd12, 1'b0, 1'b0};
        tbl[4]  = '{M_CNT, 4'd5,  4'd5, 1'b1, 4'd0,  1'b1, 1'b0};
        tbl[5]  = '{M_CNT, 4'd0,  4'd0, 1'b0, 4'd1,  1'b0, 1'b0};
        tbl[6]  = '{M_SUB, 4'd5,  4'd5, 1'b1, 4'd15, 1'b1, 1'b0};
        tbl[7]  = '{M_SUB, 4'd8,  4'd1, 1'b0, 4'd7,  1'b0, 1'b1};
        tbl[8]  = '{M_ADD, 4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0};
        tbl[9]  = '{M_ACC, 4'd15, 4'd0, 1'b0, 4'd15, 1'b0, 1'b0};
        tbl[10] = '{M_CNT, 4'd0,  4'd0, 1'b0, 4'd0,  1'b1, 1'b0};
        tbl[11] = '{M_ADD, 4'd4,  4'd4, 1'b0, 4'd8,  1'b0, 1'b1};
        tbl[12] = '{M_SUB, 4'd0,  4'd0, 1'b0, 4'd0,  1'b0, 1'b0};

        // Reset state, checked without any clock edge dependence
        #12;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.S", S, 0);
        chk("rst.Co", Co, 0);
        chk("rst.ovf", ovf, 0);
        chk("rst.zero", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) do_op($sformatf("vec%0d", i), tbl[i]);

        // Accumulator chain after clear
        do_op("pre_acc", '{M_ADD, 4'd3, 4'd3, 1'b0, 4'd6, 1'b0, 1'b0});
        do_clr();
        chk("clr.S", S, 0);
        chk("clr.zero", zero, 1);
        chk("clr.out_valid", out_valid, 0);
        burst[0] = '{M_ACC, 4'd5, 4'd0, 1'b0, 4'd5,  1'b0, 1'b0};
        burst[1] = '{M_ACC, 4'd5, 4'd0, 1'b0, 4'd10, 1'b0, 1'b1};
        burst[2] = '{M_ACC, 4'd5, 4'd0, 1'b0, 4'd15, 1'b0, 1'b0};
        burst[3] = '{M_ACC, 4'd5, 4'd0, 1'b0, 4'd4,  1'b1, 1'b0};
        run_burst("acc", 4);

        // Counter chain 1..9, wrap, 1
        do_clr();
        for (int k = 0; k < 11; k++) begin
            burst[k] = '{M_CNT, 4'd0, 4'd0, 1'b0, 4'((k + 1) % 10), (k == 9), 1'b0};
        end
        run_burst("cnt", 11);

        // Reset with two operations in flight
        drive(1'b1, M_ADD, 4'd3, 4'd4, 1'b0);
        step();
        drive(1'b1, M_ADD, 4'd5, 4'd6, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("inflight_rst.out_valid", out_valid, 0);
        chk("inflight_rst.S", S, 0);
        chk("inflight_rst.zero", zero, 1);
        drive(1'b0, M_ADD, 4'd0, 4'd0, 1'b0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst.out_valid", out_valid, 0);
            chk("post_rst.S", S, 0);
        end
        do_op("first_after_rst", '{M_ADD, 4'd9, 4'd8, 1'b1, 4'd2, 1'b1, 1'b1});

        // clr together with in_valid while another op sits in stage 1
        do_op("pre_clr", '{M_ADD, 4'd3, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0});
        drive(1'b1, M_ADD, 4'd1, 4'd1, 1'b0);
        step();
        drive(1'b1, M_ADD, 4'd2, 4'd2, 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        drive(1'b0, M_ADD, 4'd0, 4'd0, 1'b0);
        chk("clr_race.S", S, 0);
        chk("clr_race.out_valid", out_valid, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("clr_race.later_valid", out_valid, 0);
            chk("clr_race.later_S", S, 0);
        end
        do_op("after_clr", '{M_ADD, 4'd6, 4'd1, 1'b0, 4'd7, 1'b0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_count_unit.md
ADDSUB_COUNT_UNIT -- requirements
Module: addsub_count_unit

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits, legal range 2..32.
REQ-002 Parameter CNT_MAX, default 2**WIDTH-1: terminal value for COUNT mode, legal range 1..2**WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  X/Y/Cin/mode qualify an operation this cycle.
REQ-006 mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 COUNT.
REQ-007 X  input  WIDTH  operand A, unsigned; two's complement for ovf.
REQ-008 Y  input  WIDTH  operand B; ignored in ACC and COUNT.
REQ-009 Cin  input  1  carry-in for ADD/ACC, borrow-in for SUB; ignored in COUNT.
REQ-010 clr  input  1  synchronous clear of result and pipeline.
REQ-011 out_valid  output  1  S/Co/ovf/zero carry a new result this cycle.
REQ-012 S  output  WIDTH  registered result; also the accumulator/counter state.
REQ-013 Co  output  1  carry-out (ADD/ACC), borrow-out (SUB), wrap flag (COUNT).
REQ-014 ovf  output  1  signed two's-complement overflow of the result.
REQ-015 zero  output  1  high when S equals 0.

Function
REQ-016 Stage 1 registers X, Y, Cin, mode and in_valid every cycle, unconditionally.
REQ-017 Stage 2 computes from the stage-1 registers and updates S, Co, ovf and out_valid only when stage-1 valid is 1.
REQ-018 Latency is fixed: an operation presented with in_valid=1 in cycle N appears with out_valid=1 in cycle N+2.
REQ-019 Throughput is one operation per cycle; no back-pressure; no operation is dropped.
REQ-020 ADD: {Co,S} = X + Y + Cin, computed at WIDTH+1 bits.
REQ-021 SUB: S = (X - Y - Cin) mod 2**WIDTH; Co = 1 iff X < Y + Cin (unsigned borrow).
REQ-022 ACC: {Co,S} = S_current + X + Cin, where S_current is the output register value at that edge; back-to-back ACC operations chain without gaps.
REQ-023 COUNT: if S_current == CNT_MAX then S = 0 and Co = 1, else S = S_current + 1 and Co = 0.
REQ-024 COUNT with S_current > CNT_MAX (reachable after ADD/SUB/ACC) wraps to 0 with Co = 1.
REQ-025 ovf = 1 when both operands share a sign bit and the result sign differs (SUB uses the negated Y); ovf = 0 in COUNT.
REQ-026 When stage-1 valid is 0: out_valid = 0; S, Co and ovf hold their values.
REQ-027 zero is combinational from S and is valid in every cycle, independent of out_valid.
REQ-028 clr = 1 at an edge: S, Co and ovf go to 0; stage-1 valid and out_valid go to 0; any operation in stage 1 is discarded.
REQ-029 clr overrides in_valid in the same cycle; that cycle's operation is lost.
REQ-030 Mode may change on every operation; ACC and COUNT after ADD/SUB use the ADD/SUB result as S_current.

Reset
REQ-031 While rst_n = 0, independent of clk, all stage-1 registers, S, Co, ovf and out_valid are 0, and zero is 1.
REQ-032 Operations in flight when reset asserts are discarded.
REQ-033 The first operation accepted after reset deassertion appears two edges later.

Verification (WIDTH=4 unless stated)
REQ-034 ADD X=9, Y=8, Cin=1 in cycle N -> out_valid=1 in cycle N+2 with S=2, Co=1, ovf=1.
REQ-035 SUB X=3, Y=5, Cin=0 -> S=14, Co=1, ovf=0; then ADD X=7, Y=1 -> S=8, ovf=1, Co=0.
REQ-036 After clr, ACC X=5, Cin=0 for four consecutive cycles -> S=5, 10, 15, 4 in consecutive cycles; Co=1 only on the last result; out_valid stays high throughout.
REQ-037 CNT_MAX=9, COUNT for 11 consecutive cycles from S=0 -> S=1..9, 0, 1; Co=1 only when S becomes 0.
REQ-038 rst_n pulsed low while two operations are in flight -> out_valid=0, S=0 and zero=1 immediately; neither operation ever produces out_valid.
REQ-039 clr=1 and in_valid=1 in the same cycle with one operation already in stage 1 -> S=0 and no out_valid for either operation; the next operation completes normally two cycles later.
